// File: rtl/dmem_byte_seq_if.sv
// Purpose : CPU MEM-stage request/ack bundle plus byte-RAM port for dmem_byte_seq.
// Ports   : cpu_* (req/we/addr/wdata/load/store in, ack/rdata/busy/err out),
//           mem_* (addr/re/we/wdata out, rdata in). master = CPU+RAM side, slave = sequencer.
interface dmem_byte_seq_if #(
  parameter int ADDR_W = 10
);
  logic              cpu_req;
  logic              cpu_we;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [2:0]        cpu_load;
  logic [1:0]        cpu_store;
  logic              cpu_ack;
  logic [31:0]       cpu_rdata;
  logic              cpu_busy;
  logic              cpu_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_load, cpu_store, mem_rdata,
    input  cpu_ack, cpu_rdata, cpu_busy, cpu_err, mem_addr, mem_re, mem_we, mem_wdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_load, cpu_store, mem_rdata,
    output cpu_ack, cpu_rdata, cpu_busy, cpu_err, mem_addr, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/dmem_byte_seq.sv
// Purpose : sequences 8/16/32-bit little-endian CPU loads/stores onto a byte-wide
//           1-cycle-latency RAM, with sign/zero extension of load results.
// Latency : load N+2 cycles, store N+1 cycles from acceptance to ack (N = byte count).
// Backpr. : cpu_req sampled only in IDLE; requests while busy are dropped, not queued.
// Ports   : clk, rst_n (async active low), bus (dmem_byte_seq_if.slave: cpu_* and mem_*).
// Option  : DMEM_ALIGN_CHECK_EN -- misaligned half/word accesses complete at once
//           with cpu_err=1 and no RAM strobes; otherwise cpu_err is tied to 0.
module dmem_byte_seq #(
  parameter int ADDR_W = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  dmem_byte_seq_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, RD, RD_TAIL, WR, DONE} state_t;

  state_t            state_q;
  logic [31:0]       wdata_q;
  logic [2:0]        load_q;
  logic [1:0]        last_q;     // index of final byte (N-1)
  logic [1:0]        cnt_q;      // byte currently on the RAM port
  logic [31:0]       data_q;     // load bytes captured so far
  logic [31:0]       rdata_q;
  logic              ack_q;
  logic              busy_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_re_q;
  logic              mem_we_q;
  logic [7:0]        mem_wdata_q;

  logic [1:0]        req_last_d;
  logic [31:0]       ld_word_d;
  logic [31:0]       ld_ext_d;

  always_comb begin
    req_last_d = 2'd3;
    if (bus.cpu_we) begin
      case (bus.cpu_store)
        2'b00:   req_last_d = 2'd0;
        2'b01:   req_last_d = 2'd1;
        default: req_last_d = 2'd3;
      endcase
    end else begin
      case (bus.cpu_load)
        3'b000, 3'b001: req_last_d = 2'd0;
        3'b010, 3'b011: req_last_d = 2'd1;
        default:        req_last_d = 2'd3;
      endcase
    end
  end

  // In RD_TAIL the final byte is still on mem_rdata; merge it combinationally so the
  // extended result can be registered on the edge into DONE.
  always_comb begin
    ld_word_d = data_q;
    ld_word_d[{cnt_q, 3'b000} +: 8] = bus.mem_rdata;
    case (load_q)
      3'b000:  ld_ext_d = {{24{ld_word_d[7]}},  ld_word_d[7:0]};
      3'b001:  ld_ext_d = {24'd0,               ld_word_d[7:0]};
      3'b010:  ld_ext_d = {{16{ld_word_d[15]}}, ld_word_d[15:0]};
      3'b011:  ld_ext_d = {16'd0,               ld_word_d[15:0]};
      default: ld_ext_d = ld_word_d;
    endcase
  end

`ifdef DMEM_ALIGN_CHECK_EN
  logic misalign_d;
  logic err_q;
  assign misalign_d = ((req_last_d == 2'd1) && bus.cpu_addr[0]) ||
                      ((req_last_d == 2'd3) && (bus.cpu_addr[1:0] != 2'b00));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wdata_q     <= '0;
      load_q      <= '0;
      last_q      <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      rdata_q     <= '0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
`ifdef DMEM_ALIGN_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      ack_q <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
      err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (bus.cpu_req) begin
            wdata_q    <= bus.cpu_wdata;
            load_q     <= bus.cpu_load;
            last_q     <= req_last_d;
            cnt_q      <= 2'd0;
            data_q     <= '0;
            busy_q     <= 1'b1;
            mem_addr_q <= bus.cpu_addr[ADDR_W-1:0];
`ifdef DMEM_ALIGN_CHECK_EN
            if (misalign_d) begin
              state_q <= DONE;
              ack_q   <= 1'b1;
              err_q   <= 1'b1;
              rdata_q <= '0;
            end else
`endif
            begin
              if (bus.cpu_we) begin
                state_q     <= WR;
                mem_we_q    <= 1'b1;
                mem_wdata_q <= bus.cpu_wdata[7:0];
              end else begin
                state_q  <= RD;
                mem_re_q <= 1'b1;
              end
            end
          end
        end
        RD: begin
          // Byte cnt_q-1 was read on the previous edge and is on mem_rdata now.
          if (cnt_q != 2'd0)
            data_q[{cnt_q - 2'd1, 3'b000} +: 8] <= bus.mem_rdata;
          if (cnt_q == last_q) begin
            state_q  <= RD_TAIL;
            mem_re_q <= 1'b0;
          end else begin
            cnt_q      <= cnt_q + 2'd1;
            mem_addr_q <= mem_addr_q + ADDR_W'(1);
          end
        end
        RD_TAIL: begin
          rdata_q <= ld_ext_d;
          ack_q   <= 1'b1;
          state_q <= DONE;
        end
        WR: begin
          if (cnt_q == last_q) begin
            mem_we_q <= 1'b0;
            ack_q    <= 1'b1;
            rdata_q  <= '0;
            state_q  <= DONE;
          end else begin
            cnt_q       <= cnt_q + 2'd1;
            mem_addr_q  <= mem_addr_q + ADDR_W'(1);
            mem_wdata_q <= wdata_q[{cnt_q + 2'd1, 3'b000} +: 8];
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          mem_re_q <= 1'b0;
          mem_we_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cpu_ack   = ack_q;
  assign bus.cpu_rdata = rdata_q;
  assign bus.cpu_busy  = busy_q;
`ifdef DMEM_ALIGN_CHECK_EN
  assign bus.cpu_err   = err_q;
`else
  assign bus.cpu_err   = 1'b0;
`endif
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_re    = mem_re_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_byte_seq.sv
`timescale 1ns/1ps
module tb_dmem_byte_seq;
  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   overlap_cnt = 0;
  logic [7:0] ram [0:1023];
  logic [9:0] log_addr [0:7];
  int   log_n;

  dmem_byte_seq_if #(.ADDR_W(10)) bus ();
  dmem_byte_seq #(.ADDR_W(10)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte RAM: synchronous read, one-cycle latency.
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= ram[bus.mem_addr];
  end

  always @(negedge clk)
    if (rst_n && bus.mem_re && bus.mem_we) overlap_cnt++;

  // Issue one request at cycle 0 and observe cycles 1..ncyc. cpu_req stays high through
  // cycle 'hold'; after that the request fields are scrambled to show they were latched.
  task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] ld, input logic [1:0] st, input int hold, input int ncyc,
                           output int ack_cyc, output int ack_cnt, output int n_re, output int n_we,
                           output logic [31:0] rdata_ack, output logic err_seen, output logic busy1);
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    bus.cpu_load = ld; bus.cpu_store = st;
    ack_cyc = -1; ack_cnt = 0; n_re = 0; n_we = 0; rdata_ack = 32'hDEAD_BEEF;
    err_seen = 1'b0; busy1 = 1'b0; log_n = 0;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      if (c > hold) begin
        bus.cpu_req = 1'b0; bus.cpu_addr = ~addr; bus.cpu_wdata = ~wdata;
        bus.cpu_we = ~we; bus.cpu_load = ~ld; bus.cpu_store = ~st;
      end
      if (bus.cpu_ack) begin
        ack_cnt++;
        if (ack_cyc < 0) begin ack_cyc = c; rdata_ack = bus.cpu_rdata; end
      end
      if (bus.mem_re) n_re++;
      if (bus.mem_we) n_we++;
      if ((bus.mem_re || bus.mem_we) && log_n < 8) begin log_addr[log_n] = bus.mem_addr; log_n++; end
      if (bus.cpu_err) err_seen = 1'b1;
      if (c == 1) busy1 = bus.cpu_busy;
    end
  endtask

  int ac, acn, nre, nwe; logic [31:0] rd; logic er, b1;

  task automatic test_reset;
    n_checks++; if ({bus.cpu_ack, bus.cpu_busy, bus.cpu_err, bus.mem_re, bus.mem_we} !== 5'b0) begin
      n_fail++; $display("FAIL reset_strobes: got %b expected 00000",
                         {bus.cpu_ack, bus.cpu_busy, bus.cpu_err, bus.mem_re, bus.mem_we}); end
    n_checks++; if ({bus.cpu_rdata, bus.mem_addr, bus.mem_wdata} !== 50'd0) begin
      n_fail++; $display("FAIL reset_data: rdata %h addr %h wdata %h expected zeros",
                         bus.cpu_rdata, bus.mem_addr, bus.mem_wdata); end
  endtask

  task automatic test_store_word;
    do_access(1'b1, 32'h0000_0010, 32'hA1B2_C3D4, 3'b100, 2'b10, 0, 7, ac, acn, nre, nwe, rd, er, b1);
    n_checks++; if (ac !== 5) begin n_fail++; $display("FAIL sw_ack_cycle: got %0d expected 5", ac); end
    n_checks++; if (nwe !== 4 || nre !== 0) begin n_fail++; $display("FAIL sw_strobes: we %0d re %0d expected 4 0", nwe, nre); end
    n_checks++; if (b1 !== 1'b1) begin n_fail++; $display("FAIL sw_busy: got %b expected 1", b1); end
    n_checks++; if ({log_addr[0], log_addr[1], log_addr[2], log_addr[3]} !== {10'h10, 10'h11, 10'h12, 10'h13}) begin
      n_fail++; $display("FAIL sw_addrs: got %h %h %h %h expected 010 011 012 013",
                         log_addr[0], log_addr[1], log_addr[2], log_addr[3]); end
    n_checks++; if ({ram[16], ram[17], ram[18], ram[19]} !== 32'hD4C3_B2A1) begin
      n_fail++; $display("FAIL sw_bytes: got %h expected d4c3b2a1", {ram[16], ram[17], ram[18], ram[19]}); end
    n_checks++; if (rd !== 32'h0 || er !== 1'b0) begin n_fail++; $display("FAIL sw_rdata_err: got %h %b expected 0 0", rd, er); end
  endtask

  task automatic test_load_byte;
    do_access(1'b0, 32'h0000_0013, 32'h0, 3'b000, 2'b00, 0, 5, ac, acn, nre, nwe, rd, er, b1);
    n_checks++; if (ac !== 3) begin n_fail++; $display("FAIL lb_ack_cycle: got %0d expected 3", ac); end
    n_checks++; if (rd !== 32'hFFFF_FFA1) begin n_fail++; $display("FAIL lb_data: got %h expected ffffffa1", rd); end
    n_checks++; if (nre !== 1 || nwe !== 0) begin n_fail++; $display("FAIL lb_strobes: re %0d we %0d expected 1 0", nre, nwe); end
    do_access(1'b0, 32'h0000_0013, 32'h0, 3'b001, 2'b00, 0, 5, ac, acn, nre, nwe, rd, er, b1);
    n_checks++; if (rd !== 32'h0000_00A1) begin n_fail++; $display("FAIL lbu_data: got %h expected 000000a1", rd); end
    n_checks++; if (bus.cpu_rdata !== 32'h0000_00A1) begin n_fail++; $display("FAIL rdata_hold: got %h expected 000000a1", bus.cpu_rdata); end
  endtask

  task automatic test_load_half_word;
    do_access(1'b0, 32'h0000_0012, 32'h0, 3'b010, 2'b00, 0, 6, ac, acn, nre, nwe, rd, er, b1);
    n_checks++; if (rd !== 32'hFFFF_A1B2 || ac !== 4) begin n_fail++; $display("FAIL lh_data: got %h at %0d expected ffffa1b2 at 4", rd, ac); end
    do_access(1'b0, 32'h0000_0012, 32'h0, 3'b011, 2'b00, 0, 6, ac, acn, nre, nwe, rd, er, b1);
    n_checks++; if (rd !== 32'h0000_A1B2) begin n_fail++; $display("FAIL lhu_data: got %h expected 0000a1b2", rd); end
    do_access(1'b0, 32'h0000_0010, 32'h0, 3'b100, 2'b00, 0, 8, ac, acn, nre, nwe, rd, er, b1);
    n_checks++; if (rd !== 32'hA1B2_C3D4 || ac !== 6) begin n_fail++; $display("FAIL lw_data: got %h at %0d expected a1b2c3d4 at 6", rd, ac); end
    n_checks++; if (nre !== 4) begin n_fail++; $display("FAIL lw_reads: got %0d expected 4", nre); end
    do_access(1'b0, 32'h0000_0010, 32'h0, 3'b111, 2'b00, 0, 8, ac, acn, nre, nwe, rd, er, b1);
    n_checks++; if (rd !== 32'hA1B2_C3D4) begin n_fail++; $display("FAIL lw_other_code: got %h expected a1b2c3d4", rd); end
  endtask

  task automatic test_store_half_byte;
    do_access(1'b1, 32'h0000_0020, 32'h1234_5566, 3'b000, 2'b01, 0, 5, ac, acn, nre, nwe, rd, er, b1);
    n_checks++; if (ac !== 3 || nwe !== 2) begin n_fail++; $display("FAIL sh_timing: ack %0d we %0d expected 3 2", ac, nwe); end
    n_checks++; if ({ram[32], ram[33], ram[34]} !== 24'h6655_00) begin n_fail++; $display("FAIL sh_bytes: got %h expected 665500", {ram[32], ram[33], ram[34]}); end
    do_access(1'b1, 32'h0000_0022, 32'hAABB_CC77, 3'b000, 2'b00, 0, 4, ac, acn, nre, nwe, rd, er, b1);
    n_checks++; if (ac !== 2 || ram[34] !== 8'h77 || ram[35] !== 8'h00) begin
      n_fail++; $display("FAIL sb_store: ack %0d bytes %h %h expected 2 77 00", ac, ram[34], ram[35]); end
    do_access(1'b0, 32'h0000_0020, 32'h0, 3'b010, 2'b00, 0, 6, ac, acn, nre, nwe, rd, er, b1);
    n_checks++; if (rd !== 32'h0000_5566) begin n_fail++; $display("FAIL lh_positive: got %h expected 00005566", rd); end
  endtask

  task automatic test_wrap;
    do_access(1'b1, 32'h0000_03FE, 32'hCAFE_BABE, 3'b000, 2'b10, 0, 7, ac, acn, nre, nwe, rd, er, b1);
`ifdef DMEM_ALIGN_CHECK_EN
    n_checks++; if (ac !== 1 || er !== 1'b1 || nwe !== 0) begin n_fail++; $display("FAIL wrap_misaligned: ack %0d err %b we %0d expected 1 1 0", ac, er, nwe); end
    n_checks++; if (ram[1022] !== 8'h00) begin n_fail++; $display("FAIL wrap_untouched: got %h expected 00", ram[1022]); end
`else
    n_checks++; if ({ram[1022], ram[1023], ram[0], ram[1]} !== 32'hBEBA_FECA) begin
      n_fail++; $display("FAIL wrap_bytes: got %h expected bebafeca", {ram[1022], ram[1023], ram[0], ram[1]}); end
    n_checks++; if (log_addr[2] !== 10'h000 || log_addr[3] !== 10'h001) begin n_fail++; $display("FAIL wrap_addr: got %h %h expected 000 001", log_addr[2], log_addr[3]); end
    do_access(1'b0, 32'h0000_03FE, 32'h0, 3'b100, 2'b00, 0, 8, ac, acn, nre, nwe, rd, er, b1);
    n_checks++; if (rd !== 32'hCAFE_BABE) begin n_fail++; $display("FAIL wrap_load: got %h expected cafebabe", rd); end
`endif
  endtask

  task automatic test_misalign;
    do_access(1'b0, 32'h0000_0011, 32'h0, 3'b100, 2'b00, 0, 8, ac, acn, nre, nwe, rd, er, b1);
`ifdef DMEM_ALIGN_CHECK_EN
    n_checks++; if (ac !== 1 || er !== 1'b1) begin n_fail++; $display("FAIL misalign_err: ack %0d err %b expected 1 1", ac, er); end
    n_checks++; if (nre !== 0 || nwe !== 0 || rd !== 32'h0) begin n_fail++; $display("FAIL misalign_quiet: re %0d we %0d rdata %h expected 0 0 0", nre, nwe, rd); end
`else
    n_checks++; if (ac !== 6 || rd !== 32'h00A1_B2C3) begin n_fail++; $display("FAIL misalign_load: got %h at %0d expected 00a1b2c3 at 6", rd, ac); end
    n_checks++; if (er !== 1'b0 || nre !== 4) begin n_fail++; $display("FAIL misalign_err: err %b re %0d expected 0 4", er, nre); end
`endif
  endtask

  task automatic test_back_to_back;
    // Held req: sb accepted at 0, ack 2, re-accepted at 3, ack 5.
    do_access(1'b1, 32'h0000_0030, 32'h0000_005A, 3'b000, 2'b00, 5, 7, ac, acn, nre, nwe, rd, er, b1);
    n_checks++; if (acn !== 2 || nwe !== 2 || ac !== 2) begin n_fail++; $display("FAIL b2b: acks %0d we %0d first %0d expected 2 2 2", acn, nwe, ac); end
  endtask

  task automatic test_busy_ignore;
    do_access(1'b0, 32'h0000_0010, 32'h0, 3'b000, 2'b00, 2, 5, ac, acn, nre, nwe, rd, er, b1);
    n_checks++; if (acn !== 1 || nre !== 1) begin n_fail++; $display("FAIL busy_ignore: acks %0d re %0d expected 1 1", acn, nre); end
    n_checks++; if (rd !== 32'hFFFF_FFD4) begin n_fail++; $display("FAIL busy_lb: got %h expected ffffffd4", rd); end
  endtask

  task automatic test_async_reset;
    int acks;
    acks = 0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h40; bus.cpu_wdata = 32'h1122_3344; bus.cpu_store = 2'b10;
    @(posedge clk); #1; bus.cpu_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    n_checks++; if ({bus.cpu_busy, bus.mem_we, bus.mem_re, bus.cpu_ack} !== 4'b0) begin
      n_fail++; $display("FAIL arst_outputs: got %b expected 0000", {bus.cpu_busy, bus.mem_we, bus.mem_re, bus.cpu_ack}); end
    n_checks++; if (bus.cpu_rdata !== 32'h0 || bus.mem_addr !== 10'h0) begin
      n_fail++; $display("FAIL arst_data: rdata %h addr %h expected 0 0", bus.cpu_rdata, bus.mem_addr); end
    for (int c = 0; c < 3; c++) begin @(posedge clk); #1; if (bus.cpu_ack) acks++; end
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin @(posedge clk); #1; if (bus.cpu_ack) acks++; end
    n_checks++; if (acks !== 0) begin n_fail++; $display("FAIL arst_ack: got %0d expected 0", acks); end
    n_checks++; if (ram[64] !== 8'h44 || ram[65] !== 8'h00) begin n_fail++; $display("FAIL arst_bytes: got %h %h expected 44 00", ram[64], ram[65]); end
  endtask

  task automatic test_strobe_exclusive;
    n_checks++; if (overlap_cnt !== 0) begin n_fail++; $display("FAIL strobe_overlap: got %0d expected 0", overlap_cnt); end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.cpu_load = '0; bus.cpu_store = '0;
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    #2;
    test_reset;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_store_word;
    test_load_byte;
    test_load_half_word;
    test_store_half_byte;
    test_wrap;
    test_misalign;
    test_back_to_back;
    test_busy_ignore;
    test_async_reset;
    test_strobe_exclusive;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
